// File: rtl/crc5_pkg.sv
// crc5_pkg: widths, default USB polynomial and the single-bit serial CRC-5 step.
`default_nettype none

package crc5_pkg;

  localparam int CRC5_W = 5;
  localparam int DATA_W = 4;

  localparam logic [CRC5_W-1:0] CRC5_POLY_USB = 5'h05;

  // One MSB-first shift of the CRC register; x^5 is implicit in poly.
  function automatic logic [CRC5_W-1:0] crc5_step(
    input logic [CRC5_W-1:0] c,
    input logic              d,
    input logic [CRC5_W-1:0] poly
  );
    logic fb;
    fb = c[CRC5_W-1] ^ d;
    return {c[CRC5_W-2:0], 1'b0} ^ (fb ? poly : {CRC5_W{1'b0}});
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc5_step_bit.sv
// crc5_step_bit: combinational single-bit serial CRC-5 step.
`default_nettype none

module crc5_step_bit
  import crc5_pkg::*;
#(
  parameter logic [CRC5_W-1:0] CRC_POLY = CRC5_POLY_USB
) (
  input  logic [CRC5_W-1:0] crc_cur,
  input  logic              data_bit,
  output logic [CRC5_W-1:0] crc_nxt
);

  assign crc_nxt = crc5_step(crc_cur, data_bit, CRC_POLY);

endmodule

`default_nettype wire

// File: rtl/crc5_parallel_4b.sv
// crc5_parallel_4b: folds one nibble per clock (MSB first) into a registered CRC-5.
// Build option: CRC5_OUT_INV_EN drives the inverted state on crc5.
`default_nettype none

module crc5_parallel_4b
  import crc5_pkg::*;
#(
  parameter logic [CRC5_W-1:0] CRC_POLY = CRC5_POLY_USB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CRC5_W-1:0] crc5_init,
  output logic [CRC5_W-1:0] crc5
);

  logic [CRC5_W-1:0] crc_q;
  logic [CRC5_W-1:0] chain [0:DATA_W];

  assign chain[0] = crc_q;

  // Stage i consumes data_in[DATA_W-1-i], so bit 3 enters the chain first.
  generate
    for (genvar i = 0; i < DATA_W; i++) begin : g_step
      crc5_step_bit #(
        .CRC_POLY (CRC_POLY)
      ) u_step (
        .crc_cur  (chain[i]),
        .data_bit (data_in[DATA_W-1-i]),
        .crc_nxt  (chain[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_q <= crc5_init;
    end else begin
      crc_q <= chain[DATA_W];
    end
  end

`ifdef CRC5_OUT_INV_EN
  assign crc5 = ~crc_q;
`else
  assign crc5 = crc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc5_parallel_4b.sv
// tb_crc5_parallel_4b: directed checks of reset seeding, H1/H2 columns, streaming and linearity.
`default_nettype none

module tb_crc5_parallel_4b;

  logic       clk;
  logic       rst;
  logic [3:0] data_in;
  logic [4:0] crc5_init;
  logic [4:0] crc5;

  int n_cmp;
  int n_err;

`ifdef CRC5_OUT_INV_EN
  localparam logic [4:0] OUT_XOR = 5'h1F;
`else
  localparam logic [4:0] OUT_XOR = 5'h00;
`endif

  // Hand-computed columns for polynomial 5'h05.
  logic [4:0] h1 [0:3];
  logic [4:0] h2 [0:4];

  crc5_parallel_4b #(
    .CRC_POLY (5'h05)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .crc5_init (crc5_init),
    .crc5      (crc5)
  );

  initial clk = 1'b0;
  always #62 clk = ~clk;

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp_state);
    logic [4:0] exp_out;
    exp_out = exp_state ^ OUT_XOR;
    n_cmp++;
    if (got !== exp_out) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_out);
    end
  endtask

  function automatic logic [4:0] model(input logic [4:0] c, input logic [3:0] d);
    logic [4:0] s;
    logic       fb;
    s = c;
    for (int i = 3; i >= 0; i--) begin
      fb = s[4] ^ d[i];
      s  = {s[3:0], 1'b0};
      if (fb) s = s ^ 5'h05;
    end
    return s;
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic seed_then_run(input logic [4:0] seed, input logic [3:0] d);
    rst       = 1'b0;
    crc5_init = seed;
    data_in   = ~d;
    edge_step();
    rst     = 1'b1;
    data_in = d;
    edge_step();
  endtask

  initial begin
    logic [4:0] st;
    logic [4:0] exp;
    logic [4:0] ri;
    logic [3:0] rd;

    n_cmp = 0;
    n_err = 0;
    h1[0] = 5'h05; h1[1] = 5'h0A; h1[2] = 5'h14; h1[3] = 5'h0D;
    h2[0] = 5'h10; h2[1] = 5'h05; h2[2] = 5'h0A; h2[3] = 5'h14; h2[4] = 5'h0D;

    rst       = 1'b0;
    data_in   = 4'h0;
    crc5_init = 5'h00;
    edge_step();
    check_eq("reset_seed_00", crc5, 5'h00);

    for (int i = 0; i < 4; i++) begin
      seed_then_run(5'h00, 4'(1 << i));
      check_eq($sformatf("h1_col%0d", i), crc5, h1[i]);
    end

    for (int i = 0; i < 5; i++) begin
      seed_then_run(5'(1 << i), 4'h0);
      check_eq($sformatf("h2_col%0d", i), crc5, h2[i]);
    end

    rst       = 1'b0;
    crc5_init = 5'h13;
    for (int i = 0; i < 3; i++) begin
      data_in = 4'(4'h5 + 4'(i * 5));
      edge_step();
      check_eq($sformatf("reset_hold%0d", i), crc5, 5'h13);
    end

    // Last seed sampled during reset wins.
    crc5_init = 5'h07;
    edge_step();
    crc5_init = 5'h19;
    edge_step();
    check_eq("reset_last_seed", crc5, 5'h19);

    seed_then_run(5'h00, 4'h8);
    check_eq("stream0_first", crc5, 5'h0D);
    st = 5'h0D;
    for (int i = 1; i < 7; i++) begin
      edge_step();
      st = model(st, 4'h8);
      check_eq($sformatf("stream%0d", i), crc5, st);
    end
    check_eq("stream_model_sanity", 5'(crc5 ^ OUT_XOR), model(5'h0D, 4'h8) ^ 5'h0D ^ 5'h0D ^ 5'h00 ^ 5'h00 ^ st ^ model(5'h0D, 4'h8));

    rst       = 1'b0;
    crc5_init = 5'h0B;
    edge_step();
    check_eq("midstream_reload", crc5, 5'h0B);
    rst = 1'b1;
    edge_step();
    check_eq("after_reload", crc5, model(5'h0B, 4'h8));

    for (int k = 0; k < 10; k++) begin
      ri = 5'($urandom_range(0, 31));
      rd = 4'($urandom_range(0, 15));
      exp = 5'h00;
      for (int i = 0; i < 5; i++) if (ri[i]) exp = exp ^ h2[i];
      for (int i = 0; i < 4; i++) if (rd[i]) exp = exp ^ h1[i];
      seed_then_run(ri, rd);
      check_eq($sformatf("linear_%h_%h", ri, rd), crc5, exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crc5_parallel_4b.md
# crc5_parallel_4b

4-bit-per-clock parallel CRC-5 generator (polynomial x^5+x^2+1, USB style). It sits on a nibble-wide data path. Each clock it folds one 4-bit symbol into a registered 5-bit CRC state. While the block is held in reset, the state is preloaded from a seed input. The result is a continuously available registered CRC, which also serves to extract the H matrices of the parallel update equation.

## Interface
- CRC_POLY, default 5'h05: generator polynomial low terms (x^5 implicit); 5'h05 gives x^5+x^2+1.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-low; loads the seed.
- data_in  input  4  data nibble; bit 3 is processed first (MSB first).
- crc5_init  input  5  seed value loaded into the CRC state while rst is low.
- crc5  output  5  registered CRC state (optionally inverted, see Configuration).

## Operation
- State register `crc_q[4:0]`.
- Serial step for one data bit d applied to state c:
  - fb = c[4] ^ d
  - next = {c[3:0], 1'b0} ^ (fb ? CRC_POLY : 5'h00)
- Parallel update is four chained serial steps:
  - data_in[3] first, then data_in[2], data_in[1], data_in[0].
  - `crc_next = step(step(step(step(crc_q, d3), d2), d1), d0)`.
- The update is linear: crc_next = H2·crc_q ⊕ H1·data_in over GF(2).
  - Columns of H1 come from crc_q=0 with one-hot data.
  - Columns of H2 come from data=0 with one-hot crc_q.
- rst low at a rising edge: crc_q <= crc5_init. data_in is ignored.
- rst high at a rising edge: crc_q <= crc_next. The update happens every cycle; there is no enable and no hold state.
- crc5 = crc_q, or ~crc_q when CRC5_OUT_INV_EN is defined.
- No state machine. No internal counters.

## Timing
- Latency is one clock: crc5 reflects the data_in sampled at the previous rising edge.
- Reset value of crc5: crc5_init as sampled at the last edge with rst low, inverted if CRC5_OUT_INV_EN is defined.
  - There is no fixed constant reset value.
  - Before the first clock edge the output is unknown.
- Reset mid-operation: the next edge with rst low discards the accumulated state and loads the seed.
- crc5_init changing during reset: the last sampled value wins.
- First edge after rst returns high: crc_q <= crc_next(crc5_init, data_in).
- The combinational path (4 chained XOR steps) must close in one clk period. The design target is 8 MHz (125 ns period) minimum.
- Outputs are glitch-free (direct register outputs; the inverter is the only logic).

## Configuration
- Macro `CRC5_OUT_INV_EN`:
  - Defined: crc5 = ~crc_q (USB final-XOR 5'h1F convention). The internal state and update are unchanged.
  - Undefined: crc5 = crc_q (raw state, required for H-matrix extraction).

## Structure
- Package `crc5_pkg` holds:
  - `CRC5_W = 5` and `DATA_W = 4`.
  - Default polynomial constant `CRC5_POLY_USB = 5'h05`.
  - The pure function `crc5_step(c, d, poly)`.
- Sub-module `crc5_step_bit`: combinational single-bit serial step.
  - Instantiated 4× in a generate chain, MSB of data_in first.
  - The top level holds only the chain, the state register and the output stage.

## Test plan
Default polynomial 5'h05, macro undefined, check crc5 one edge after rst returns high.
- H1 columns, crc5_init=5'h00:
  - data_in=4'h1 -> 5'h05
  - data_in=4'h2 -> 5'h0A
  - data_in=4'h4 -> 5'h14
  - data_in=4'h8 -> 5'h0D
- H2 columns, data_in=4'h0:
  - init 5'h01 -> 5'h10
  - init 5'h02 -> 5'h05
  - init 5'h04 -> 5'h0A
  - init 5'h08 -> 5'h14
  - init 5'h10 -> 5'h0D
- Reset hold: rst low for 3 edges with crc5_init=5'h13 -> crc5=5'h13 on each edge, regardless of data_in.
- Continuous run: init 5'h00, data_in held at 4'h8 -> successive crc5 values match the bit-serial model each cycle (first value 5'h0D). Then a rst pulse mid-stream reloads the seed on the next edge.
- Linearity: random init/data pairs -> crc5 equals H2·init ⊕ H1·data from the extracted columns.
- CRC5_OUT_INV_EN defined: init 5'h00, data 4'h1 -> crc5=5'h1A; during reset with init 5'h00 -> crc5=5'h1F.
